// File: rtl/led_pwm_ctrl_if.sv
// PicoSoC iomem bus bundle for the LED controller.
// The master drives the request; the slave returns a one-cycle ack with read data.
interface led_pwm_ctrl_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                  input  iomem_ready, iomem_rdata);
  modport slave  (input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                  output iomem_ready, iomem_rdata);
endinterface

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped red/green LED controller: off/on/PWM/blink per channel,
// with a shared prescaler tick driving the PWM and blink counters.
module led_pwm_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int          PWM_BITS  = 8
) (
  input  logic           clk,
  input  logic           resetn,
  led_pwm_ctrl_if.slave  bus,
  output logic           ledr_n,
  output logic           ledg_n
);
  localparam logic [5:0] W_CTRL = 6'h0, W_PRE = 6'h1, W_DUTY = 6'h2,
                         W_BLINK = 6'h3, W_STAT = 6'h4;

  logic [3:0]          ctrl;
  logic [15:0]         prescale, blink_len, pre_cnt, blink_cnt;
  logic [PWM_BITS-1:0] duty_r, duty_g, pwm_cnt;
  logic                phase;
  logic                sel, acc, wr, wr_pre, wr_blink, tick, lvl_r, lvl_g;
  logic [5:0]          word;
  logic [31:0]         rd_val;
  logic                unused_bits;

  assign sel      = bus.iomem_valid && (bus.iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign acc      = sel && !bus.iomem_ready;
  assign wr       = acc && (bus.iomem_wstrb != 4'b0);
  assign word     = bus.iomem_addr[7:2];
  assign wr_pre   = wr && (word == W_PRE);
  assign wr_blink = wr && (word == W_BLINK);
  assign tick     = (pre_cnt == prescale);
  assign unused_bits = ^{bus.iomem_addr[1:0], bus.iomem_wdata[31:16], bus.iomem_wstrb[3:2]};

  always_comb begin
    rd_val = '0;
    case (word)
      W_CTRL:  rd_val = {28'h0, ctrl};
      W_PRE:   rd_val = {16'h0, prescale};
      W_DUTY:  rd_val = {16'h0, 8'(duty_g), 8'(duty_r)};
      W_BLINK: rd_val = {16'h0, blink_len};
      W_STAT:  rd_val = {16'h0, 8'(pwm_cnt), 7'h0, phase};
      default: rd_val = '0;
    endcase
  end

  function automatic logic chan_level(input logic [1:0] mode,
                                      input logic [PWM_BITS-1:0] duty,
                                      input logic [PWM_BITS-1:0] cnt,
                                      input logic ph);
    case (mode)
      2'd0:    return 1'b0;
      2'd1:    return 1'b1;
      2'd2:    return cnt < duty;
      default: return ph;
    endcase
  endfunction

  assign lvl_r = chan_level(ctrl[1:0], duty_r, pwm_cnt, phase);
  assign lvl_g = chan_level(ctrl[3:2], duty_g, pwm_cnt, phase);

  // Ready is forced low every other cycle so a held request is never double-acked.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.iomem_ready <= 1'b0;
      bus.iomem_rdata <= '0;
    end else begin
      bus.iomem_ready <= acc;
      bus.iomem_rdata <= acc ? rd_val : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl      <= '0;
      prescale  <= '0;
      duty_r    <= '0;
      duty_g    <= '0;
      blink_len <= '0;
    end else if (wr) begin
      case (word)
        W_CTRL: if (bus.iomem_wstrb[0]) ctrl <= bus.iomem_wdata[3:0];
        W_PRE: begin
          if (bus.iomem_wstrb[0]) prescale[7:0]  <= bus.iomem_wdata[7:0];
          if (bus.iomem_wstrb[1]) prescale[15:8] <= bus.iomem_wdata[15:8];
        end
        W_DUTY: begin
          if (bus.iomem_wstrb[0]) duty_r <= bus.iomem_wdata[PWM_BITS-1:0];
          if (bus.iomem_wstrb[1]) duty_g <= bus.iomem_wdata[8 +: PWM_BITS];
        end
        W_BLINK: begin
          if (bus.iomem_wstrb[0]) blink_len[7:0]  <= bus.iomem_wdata[7:0];
          if (bus.iomem_wstrb[1]) blink_len[15:8] <= bus.iomem_wdata[15:8];
        end
        default: ;
      endcase
    end
  end

  // Counters run on the pre-write config; a write to PRESCALE/BLINK clears its counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_cnt   <= '0;
      pwm_cnt   <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      if (wr_pre || tick) pre_cnt <= '0;
      else                pre_cnt <= pre_cnt + 16'd1;
      if (tick) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (wr_blink)
        blink_cnt <= '0;
      else if (tick)
        blink_cnt <= (blink_cnt == blink_len) ? 16'd0 : blink_cnt + 16'd1;
      if (tick && (blink_cnt == blink_len)) phase <= ~phase;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ledr_n <= 1'b1;
      ledg_n <= 1'b1;
    end else begin
      ledr_n <= ~lvl_r;
      ledg_n <= ~lvl_g;
    end
  end
endmodule
